// File: rtl/debug_pkg.sv
// Shared definitions for the debug module: DMI register addresses, abstract
// command error codes and the state encodings of the run-control and abstract FSMs.
package debug_pkg;

  localparam logic [6:0] DM_DATA0      = 7'h04;
  localparam logic [6:0] DM_DMCONTROL  = 7'h10;
  localparam logic [6:0] DM_DMSTATUS   = 7'h11;
  localparam logic [6:0] DM_ABSTRACTCS = 7'h16;
  localparam logic [6:0] DM_COMMAND    = 7'h17;

  localparam logic [3:0] DM_VERSION     = 4'd2;
  localparam logic [3:0] DM_DATACOUNT   = 4'd1;
  localparam logic [4:0] DM_PROGBUFSIZE = 5'd0;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  typedef enum logic {
    R_IDLE,
    R_RESUME
  } run_state_e;

  typedef enum logic [1:0] {
    A_IDLE,
    A_ACCESS,
    A_RDWAIT
  } abs_state_e;

  // Registers reachable by Access Register: dcsr, dpc and the GPRs x0..x31.
  function automatic logic regno_valid(input logic [15:0] regno);
    return (regno == 16'h07b0) || (regno == 16'h07b1) ||
           ((regno >= 16'h1000) && (regno <= 16'h101f));
  endfunction

endpackage

// File: rtl/dm_abs_cmd.sv
// Abstract command engine: validates Access Register commands, sequences the
// core's abstract register port and owns cmderr and data0.
module dm_abs_cmd
  import debug_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        active,
  input  logic        wr_command,
  input  logic        wr_data0,
  input  logic        wr_abstractcs,
  input  logic [31:0] wdata,
  input  logic        core_halted,
  output logic        busy,
  output logic [2:0]  cmderr,
  output logic [31:0] data0,
  output logic        ar_en,
  output logic        ar_wr,
  output logic [15:0] ar_ad,
  output logic [31:0] ar_do,
  input  logic [31:0] ar_di
);

  abs_state_e  state_q, state_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic [31:0] data0_q, data0_d;
  logic        acc_wr_q, acc_wr_d;
  logic [15:0] acc_regno_q, acc_regno_d;

  logic [7:0]  cmd_type;
  logic [2:0]  cmd_aarsize;
  logic        cmd_postexec, cmd_transfer, cmd_write;
  logic [15:0] cmd_regno;

  assign cmd_type     = wdata[31:24];
  assign cmd_aarsize  = wdata[22:20];
  assign cmd_postexec = wdata[18];
  assign cmd_transfer = wdata[17];
  assign cmd_write    = wdata[16];
  assign cmd_regno    = wdata[15:0];

  assign busy = (state_q != A_IDLE);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cmderr_d    = cmderr_q;
    data0_d     = data0_q;
    acc_wr_d    = acc_wr_q;
    acc_regno_d = acc_regno_q;

    case (state_q)
      A_ACCESS: state_d = acc_wr_q ? A_IDLE : A_RDWAIT;
      A_RDWAIT: begin
        data0_d = ar_di;
        state_d = A_IDLE;
      end
      default: ;
    endcase

    if (busy) begin
      // Touching command state mid-access is flagged and the write itself is dropped.
      if ((wr_command || wr_data0 || wr_abstractcs) && (cmderr_q == CMDERR_NONE))
        cmderr_d = CMDERR_BUSY;
    end else begin
      if (wr_abstractcs) cmderr_d = cmderr_q & ~wdata[10:8];
      if (wr_data0)      data0_d  = wdata;
      if (wr_command && (cmderr_q == CMDERR_NONE)) begin
        if ((cmd_type != 8'd0) || (cmd_aarsize != 3'd2) || cmd_postexec ||
            (cmd_transfer && !regno_valid(cmd_regno)))
          cmderr_d = CMDERR_NOTSUP;
        else if (!core_halted)
          cmderr_d = CMDERR_HALTRESUME;
        else if (cmd_transfer) begin
          state_d     = A_ACCESS;
          acc_wr_d    = cmd_write;
          acc_regno_d = cmd_regno;
        end
      end
    end

    if (!active) begin
      state_d     = A_IDLE;
      cmderr_d    = CMDERR_NONE;
      data0_d     = '0;
      acc_wr_d    = 1'b0;
      acc_regno_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= A_IDLE;
      cmderr_q    <= CMDERR_NONE;
      data0_q     <= '0;
      acc_wr_q    <= 1'b0;
      acc_regno_q <= '0;
    end else begin
      state_q     <= state_d;
      cmderr_q    <= cmderr_d;
      data0_q     <= data0_d;
      acc_wr_q    <= acc_wr_d;
      acc_regno_q <= acc_regno_d;
    end
  end

  assign cmderr = cmderr_q;
  assign data0  = data0_q;
  assign ar_en  = (state_q == A_ACCESS);
  assign ar_wr  = ar_en & acc_wr_q;
  assign ar_ad  = ar_en ? acc_regno_q : 16'h0000;
  assign ar_do  = ar_en ? data0_q : 32'h0000_0000;

endmodule

// File: rtl/dm_ctrl.sv
// Debug-module controller for one hart: DMI register decode, halt/resume
// handshake with the core, and the abstract command engine instance.
module dm_ctrl
  import debug_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        dmi_req_i,
  input  logic        dmi_wr_i,
  input  logic [6:0]  dmi_addr_i,
  input  logic [31:0] dmi_wdata_i,
  output logic [31:0] dmi_rdata_o,
  output logic        dmi_rvalid_o,
  output logic        dbg_haltreq_o,
  output logic        dbg_resumereq_o,
  input  logic        core_resumeack_i,
  input  logic        core_running_i,
  input  logic        core_halted_i,
  output logic        dbg_ar_en,
  output logic        dbg_ar_wr,
  output logic [15:0] dbg_ar_ad,
  output logic [31:0] dbg_ar_do,
  input  logic [31:0] dbg_ar_di
);

  logic wr_req, rd_req;
  logic wr_data0, wr_dmcontrol, wr_abstractcs, wr_command;

  assign wr_req        = dmi_req_i & dmi_wr_i;
  assign rd_req        = dmi_req_i & ~dmi_wr_i;
  assign wr_data0      = wr_req && (dmi_addr_i == DM_DATA0);
  assign wr_dmcontrol  = wr_req && (dmi_addr_i == DM_DMCONTROL);
  assign wr_abstractcs = wr_req && (dmi_addr_i == DM_ABSTRACTCS);
  assign wr_command    = wr_req && (dmi_addr_i == DM_COMMAND);

  logic        dmactive_q, dmactive_d;
  logic        haltreq_q, haltreq_d;
  run_state_e  run_q, run_d;
  logic        resumeack_q, resumeack_d;
  logic        busy;
  logic [2:0]  cmderr;
  logic [31:0] data0;
  logic [31:0] rdata_d, rdata_q;
  logic        rvalid_q;

  // The written dmactive value gates the same write, so one access both
  // activates the DM and issues a request, and clearing it aborts at once.
  always_comb begin
    dmactive_d = dmactive_q;
    haltreq_d  = haltreq_q;
    if (wr_dmcontrol) begin
      dmactive_d = dmi_wdata_i[0];
      haltreq_d  = dmi_wdata_i[31] & dmi_wdata_i[0];
    end
  end

  always_comb begin
    run_d       = run_q;
    resumeack_d = resumeack_q;
    case (run_q)
      R_IDLE: begin
        if (wr_dmcontrol && dmi_wdata_i[0] && dmi_wdata_i[30] && !dmi_wdata_i[31] &&
            core_halted_i) begin
          resumeack_d = 1'b0;
          run_d       = R_RESUME;
        end
      end
      R_RESUME: begin
        if (core_resumeack_i) begin
          resumeack_d = 1'b1;
          run_d       = R_IDLE;
        end
      end
      default: run_d = R_IDLE;
    endcase
    if (!dmactive_d) begin
      run_d       = R_IDLE;
      resumeack_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_req) begin
      case (dmi_addr_i)
        DM_DATA0:      rdata_d = data0;
        DM_DMCONTROL:  rdata_d = {haltreq_q, 30'd0, dmactive_q};
        DM_DMSTATUS:   rdata_d = {14'd0, resumeack_q, resumeack_q, 4'd0,
                                  core_running_i, core_running_i,
                                  core_halted_i, core_halted_i,
                                  1'b1, 3'd0, DM_VERSION};
        DM_ABSTRACTCS: rdata_d = {3'd0, DM_PROGBUFSIZE, 11'd0, busy, 1'b0,
                                  cmderr, 4'd0, DM_DATACOUNT};
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      dmactive_q  <= 1'b0;
      haltreq_q   <= 1'b0;
      run_q       <= R_IDLE;
      resumeack_q <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      dmactive_q  <= dmactive_d;
      haltreq_q   <= haltreq_d;
      run_q       <= run_d;
      resumeack_q <= resumeack_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rd_req;
    end
  end

  dm_abs_cmd u_abs_cmd (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .active        (dmactive_d),
    .wr_command    (wr_command),
    .wr_data0      (wr_data0),
    .wr_abstractcs (wr_abstractcs),
    .wdata         (dmi_wdata_i),
    .core_halted   (core_halted_i),
    .busy          (busy),
    .cmderr        (cmderr),
    .data0         (data0),
    .ar_en         (dbg_ar_en),
    .ar_wr         (dbg_ar_wr),
    .ar_ad         (dbg_ar_ad),
    .ar_do         (dbg_ar_do),
    .ar_di         (dbg_ar_di)
  );

  assign dmi_rdata_o     = rdata_q;
  assign dmi_rvalid_o    = rvalid_q;
  assign dbg_haltreq_o   = haltreq_q;
  assign dbg_resumereq_o = (run_q == R_RESUME);

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: a register-access vector table, a read-data
// scoreboard, and hand-written sequences for run control and abstract commands.
module tb_dm_ctrl;
  import debug_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        dmi_req_i = 1'b0;
  logic        dmi_wr_i = 1'b0;
  logic [6:0]  dmi_addr_i = '0;
  logic [31:0] dmi_wdata_i = '0;
  logic [31:0] dmi_rdata_o;
  logic        dmi_rvalid_o;
  logic        dbg_haltreq_o;
  logic        dbg_resumereq_o;
  logic        core_resumeack_i = 1'b0;
  logic        core_running_i = 1'b1;
  logic        core_halted_i = 1'b0;
  logic        dbg_ar_en;
  logic        dbg_ar_wr;
  logic [15:0] dbg_ar_ad;
  logic [31:0] dbg_ar_do;
  logic [31:0] dbg_ar_di = '0;

  dm_ctrl dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .dmi_req_i        (dmi_req_i),
    .dmi_wr_i         (dmi_wr_i),
    .dmi_addr_i       (dmi_addr_i),
    .dmi_wdata_i      (dmi_wdata_i),
    .dmi_rdata_o      (dmi_rdata_o),
    .dmi_rvalid_o     (dmi_rvalid_o),
    .dbg_haltreq_o    (dbg_haltreq_o),
    .dbg_resumereq_o  (dbg_resumereq_o),
    .core_resumeack_i (core_resumeack_i),
    .core_running_i   (core_running_i),
    .core_halted_i    (core_halted_i),
    .dbg_ar_en        (dbg_ar_en),
    .dbg_ar_wr        (dbg_ar_wr),
    .dbg_ar_ad        (dbg_ar_ad),
    .dbg_ar_do        (dbg_ar_do),
    .dbg_ar_di        (dbg_ar_di)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All helpers start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic dmi_write(input logic [6:0] addr, input logic [31:0] wdata);
    dmi_req_i = 1'b1;
    dmi_wr_i = 1'b1;
    dmi_addr_i = addr;
    dmi_wdata_i = wdata;
    step();
    dmi_req_i = 1'b0;
    dmi_wr_i = 1'b0;
  endtask

  task automatic dmi_read(input string name, input logic [6:0] addr, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp = exp;
    sb_q.push_back(e);
    dmi_req_i = 1'b1;
    dmi_wr_i = 1'b0;
    dmi_addr_i = addr;
    step();
    dmi_req_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (dmi_rvalid_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: rvalid with no pending read, rdata=0x%08h", dmi_rdata_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, dmi_rdata_o, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bad_cmds [4];

    vecs[0]  = '{1'b1, DM_DMCONTROL,  32'h0000_0001, 32'h0};
    vecs[1]  = '{1'b0, DM_DMCONTROL,  32'h0,         32'h0000_0001};
    vecs[2]  = '{1'b0, DM_DMSTATUS,   32'h0,         32'h0000_0C82};
    vecs[3]  = '{1'b0, DM_ABSTRACTCS, 32'h0,         32'h0000_0001};
    vecs[4]  = '{1'b0, DM_DATA0,      32'h0,         32'h0000_0000};
    vecs[5]  = '{1'b1, DM_DATA0,      32'h1234_5678, 32'h0};
    vecs[6]  = '{1'b0, DM_DATA0,      32'h0,         32'h1234_5678};
    vecs[7]  = '{1'b0, DM_COMMAND,    32'h0,         32'h0000_0000};
    vecs[8]  = '{1'b1, 7'h05,         32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{1'b0, 7'h05,         32'h0,         32'h0000_0000};
    vecs[10] = '{1'b1, DM_DMCONTROL,  32'h4000_0001, 32'h0};
    vecs[11] = '{1'b0, DM_DMCONTROL,  32'h0,         32'h0000_0001};
    vecs[12] = '{1'b0, DM_DMSTATUS,   32'h0,         32'h0000_0C82};

    // Reset: every output low while reset is held.
    step();
    step();
    check("rst_haltreq", {31'd0, dbg_haltreq_o}, 32'd0);
    check("rst_resumereq", {31'd0, dbg_resumereq_o}, 32'd0);
    check("rst_ar_en", {31'd0, dbg_ar_en}, 32'd0);
    check("rst_rvalid", {31'd0, dmi_rvalid_o}, 32'd0);
    check("rst_rdata", dmi_rdata_o, 32'd0);
    reset_ni = 1'b1;
    step();

    // Register decode, with a running core.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) dmi_write(vecs[i].addr, vecs[i].wdata);
      else dmi_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    step();
    check("idle_haltreq", {31'd0, dbg_haltreq_o}, 32'd0);
    check("idle_resumereq", {31'd0, dbg_resumereq_o}, 32'd0);
    check("idle_ar_en", {31'd0, dbg_ar_en}, 32'd0);

    // Halt request, then the core halts.
    dmi_write(DM_DMCONTROL, 32'h8000_0001);
    check("halt_req_rise", {31'd0, dbg_haltreq_o}, 32'd1);
    dmi_read("halt_dmcontrol", DM_DMCONTROL, 32'h8000_0001);
    core_running_i = 1'b0;
    core_halted_i = 1'b1;
    step();
    dmi_read("halt_dmstatus", DM_DMSTATUS, 32'h0000_0382);

    // haltreq wins over resumereq.
    dmi_write(DM_DMCONTROL, 32'hC000_0001);
    check("both_haltreq", {31'd0, dbg_haltreq_o}, 32'd1);
    check("both_resumereq", {31'd0, dbg_resumereq_o}, 32'd0);

    // Resume handshake.
    dmi_write(DM_DMCONTROL, 32'h4000_0001);
    check("res_haltreq_drop", {31'd0, dbg_haltreq_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("res_hold%0d", i), {31'd0, dbg_resumereq_o}, 32'd1);
      step();
    end
    core_resumeack_i = 1'b1;
    check("res_at_ack", {31'd0, dbg_resumereq_o}, 32'd1);
    step();
    check("res_after_ack", {31'd0, dbg_resumereq_o}, 32'd0);
    core_resumeack_i = 1'b0;
    core_halted_i = 1'b0;
    core_running_i = 1'b1;
    step();
    dmi_read("res_dmstatus", DM_DMSTATUS, 32'h0003_0C82);
    dmi_read("res_dmcontrol", DM_DMCONTROL, 32'h0000_0001);

    // Halt again for abstract commands.
    dmi_write(DM_DMCONTROL, 32'h8000_0001);
    core_running_i = 1'b0;
    core_halted_i = 1'b1;
    step();

    // Write dpc.
    dmi_write(DM_DATA0, 32'h8000_0100);
    dmi_write(DM_COMMAND, 32'h0023_07b1);
    check("wdpc_en", {31'd0, dbg_ar_en}, 32'd1);
    check("wdpc_wr", {31'd0, dbg_ar_wr}, 32'd1);
    check("wdpc_ad", {16'd0, dbg_ar_ad}, 32'h0000_07b1);
    check("wdpc_do", dbg_ar_do, 32'h8000_0100);
    step();
    check("wdpc_en_once", {31'd0, dbg_ar_en}, 32'd0);
    dmi_read("wdpc_abstractcs", DM_ABSTRACTCS, 32'h0000_0001);

    // Read x5; busy is visible while the access is in flight.
    dmi_write(DM_COMMAND, 32'h0022_1005);
    check("rx5_en", {31'd0, dbg_ar_en}, 32'd1);
    check("rx5_wr", {31'd0, dbg_ar_wr}, 32'd0);
    check("rx5_ad", {16'd0, dbg_ar_ad}, 32'h0000_1005);
    dmi_read("rx5_busy", DM_ABSTRACTCS, 32'h0000_1001);
    check("rx5_en_once", {31'd0, dbg_ar_en}, 32'd0);
    dbg_ar_di = 32'hDEAD_BEEF;
    step();
    dbg_ar_di = 32'h0;
    dmi_read("rx5_data0", DM_DATA0, 32'hDEAD_BEEF);
    dmi_read("rx5_abstractcs", DM_ABSTRACTCS, 32'h0000_0001);

    // data0 write while busy: cmderr=1 and the write is dropped.
    dmi_write(DM_COMMAND, 32'h0022_1000);
    dmi_write(DM_DATA0, 32'h1111_1111);
    dbg_ar_di = 32'h5555_AAAA;
    step();
    dbg_ar_di = 32'h0;
    dmi_read("busy_cmderr", DM_ABSTRACTCS, 32'h0000_0101);
    dmi_read("busy_data0", DM_DATA0, 32'h5555_AAAA);
    dmi_write(DM_COMMAND, 32'h0023_07b0);
    check("busy_cmd_blocked", {31'd0, dbg_ar_en}, 32'd0);
    dmi_write(DM_ABSTRACTCS, 32'h0000_0700);
    dmi_read("busy_w1c", DM_ABSTRACTCS, 32'h0000_0001);

    // Unsupported commands: aarsize=3, postexec, bad regno, cmdtype!=0.
    bad_cmds[0] = 32'h0033_07b1;
    bad_cmds[1] = 32'h0027_07b1;
    bad_cmds[2] = 32'h0023_0005;
    bad_cmds[3] = 32'h0123_07b1;
    for (int i = 0; i < 4; i++) begin
      dmi_write(DM_COMMAND, bad_cmds[i]);
      check($sformatf("notsup%0d_en", i), {31'd0, dbg_ar_en}, 32'd0);
      dmi_read($sformatf("notsup%0d_cmderr", i), DM_ABSTRACTCS, 32'h0000_0201);
      dmi_write(DM_ABSTRACTCS, 32'h0000_0700);
    end

    // transfer=0 completes with no access and no error, even with a bad regno.
    dmi_write(DM_COMMAND, 32'h0020_0005);
    check("notransfer_en", {31'd0, dbg_ar_en}, 32'd0);
    dmi_read("notransfer_abstractcs", DM_ABSTRACTCS, 32'h0000_0001);

    // Command while the core runs.
    core_halted_i = 1'b0;
    core_running_i = 1'b1;
    dmi_write(DM_COMMAND, 32'h0023_07b1);
    check("running_en", {31'd0, dbg_ar_en}, 32'd0);
    dmi_read("running_cmderr", DM_ABSTRACTCS, 32'h0000_0401);
    dmi_write(DM_ABSTRACTCS, 32'h0000_0700);
    dmi_read("running_w1c", DM_ABSTRACTCS, 32'h0000_0001);
    core_halted_i = 1'b1;
    core_running_i = 1'b0;

    // Clearing dmactive mid-command aborts it and resets DM state.
    dmi_write(DM_COMMAND, 32'h0022_1001);
    check("drop_en", {31'd0, dbg_ar_en}, 32'd1);
    dmi_write(DM_DMCONTROL, 32'h0000_0000);
    dbg_ar_di = 32'h0BAD_F00D;
    check("drop_en_after", {31'd0, dbg_ar_en}, 32'd0);
    check("drop_haltreq", {31'd0, dbg_haltreq_o}, 32'd0);
    dmi_read("drop_abstractcs", DM_ABSTRACTCS, 32'h0000_0001);
    dbg_ar_di = 32'h0;
    dmi_write(DM_DMCONTROL, 32'h0000_0001);
    dmi_read("drop_data0", DM_DATA0, 32'h0000_0000);

    // Asynchronous reset during an access.
    dmi_write(DM_COMMAND, 32'h0022_1002);
    check("rstmid_en_before", {31'd0, dbg_ar_en}, 32'd1);
    #1 reset_ni = 1'b0;
    #1 check("rstmid_en_async", {31'd0, dbg_ar_en}, 32'd0);
    step();
    reset_ni = 1'b1;
    step();
    check("rstmid_en_after", {31'd0, dbg_ar_en}, 32'd0);
    dmi_read("rstmid_dmcontrol", DM_DMCONTROL, 32'h0000_0000);
    step();
    step();
    check("sb_drain", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
